// File: rtl/wb_regbank_if.sv
// wb_regbank_if: Wishbone classic-with-stall bus bundle between an interconnect master and a register slave
// master drives: cyc_i, stb_i, adr_i[AW-1:0] (word address), sel_i[3:0], we_i, dat_i[31:0]
// slave drives:  ack_o, err_o, rty_o, stall_o, dat_o[31:0]
interface wb_regbank_if #(parameter int AW = 2);
  logic          cyc_i;
  logic          stb_i;
  logic [AW-1:0] adr_i;
  logic [3:0]    sel_i;
  logic          we_i;
  logic [31:0]   dat_i;
  logic          ack_o;
  logic          err_o;
  logic          rty_o;
  logic          stall_o;
  logic [31:0]   dat_o;
  modport master (output cyc_i, stb_i, adr_i, sel_i, we_i, dat_i, input ack_o, err_o, rty_o, stall_o, dat_o);
  modport slave (input cyc_i, stb_i, adr_i, sel_i, we_i, dat_i, output ack_o, err_o, rty_o, stall_o, dat_o);
endinterface

// File: rtl/wb_regbank.sv
// wb_regbank: Wishbone slave bank of NREGS 32-bit registers with byte-lane writes and optional pipe stages
// clk_i/rst_i: clock and synchronous active-high reset
// wb: slave side of wb_regbank_if (its AW must equal max(1, clog2(NREGS)))
// regs_o: register i at [32i+31:32i]; wr_stb_o[i]: one-cycle pulse with the write ack of register i
module wb_regbank #(
  parameter int          NREGS        = 4,
  parameter bit          PIPE_WR      = 1'b1,
  parameter bit          PIPE_RD      = 1'b1,
  parameter bit          ERR_UNMAPPED = 1'b0,
  parameter logic [31:0] RST_VAL      = 32'h0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  wb_regbank_if.slave        wb,
  output logic [32*NREGS-1:0] regs_o,
  output logic [NREGS-1:0]   wr_stb_o
);
  localparam int AW = NREGS > 1 ? $clog2(NREGS) : 1;
  logic en, acc_w, acc_r, wip_q, wip_d, rip_q, rip_d;
  logic wv_q, dv, wmap;
  logic [AW-1:0] wa_q, da;
  logic [31:0] wd_q, dd, dm;
  logic [3:0] ws_q, ds;
  logic rv_q, rm_q, rmap, fv, fm;
  logic [31:0] rd_q, rmux, fd;
  logic ack_q, ack_d, err_q, err_d;
  logic [31:0] dat_q, dat_d;
  logic [NREGS-1:0][31:0] regs_q, regs_d;
  logic [NREGS-1:0] stb_q, stb_d;
  always_comb begin
    en = wb.cyc_i & wb.stb_i;
    // one transfer in flight at a time; the flag holds until the response cycle has passed
    acc_w = en & wb.we_i & ~wip_q & ~rip_q;
    acc_r = en & ~wb.we_i & ~wip_q & ~rip_q;
    dv = PIPE_WR ? wv_q : acc_w;
    da = PIPE_WR ? wa_q : wb.adr_i;
    dd = PIPE_WR ? wd_q : wb.dat_i;
    ds = PIPE_WR ? ws_q : wb.sel_i;
    dm = {{8{ds[3]}}, {8{ds[2]}}, {8{ds[1]}}, {8{ds[0]}}};
    wmap = {1'b0, da} < (AW+1)'(NREGS);
    rmap = {1'b0, wb.adr_i} < (AW+1)'(NREGS);
    rmux = '0;
    regs_d = regs_q;
    stb_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      rmux = wb.adr_i == AW'(i) ? regs_q[i] : rmux;
      regs_d[i] = dv && da == AW'(i) ? (dd & dm) | (regs_q[i] & ~dm) : regs_q[i];
      stb_d[i] = dv && da == AW'(i);
    end
    fv = PIPE_RD ? rv_q : acc_r;
    fm = PIPE_RD ? rm_q : rmap;
    fd = PIPE_RD ? rd_q : rmux;
    ack_d = (dv & (wmap | ~ERR_UNMAPPED)) | (fv & (fm | ~ERR_UNMAPPED));
    err_d = ERR_UNMAPPED & ((dv & ~wmap) | (fv & ~fm));
    dat_d = fv ? fd : dat_q;
    wip_d = wip_q ? ~(ack_q | err_q) : acc_w;
    rip_d = rip_q ? ~(ack_q | err_q) : acc_r;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      regs_q <= {NREGS{RST_VAL}};
      stb_q <= '0;
      {ack_q, err_q, wip_q, rip_q, wv_q, rv_q, rm_q} <= '0;
      {dat_q, rd_q, wd_q} <= '0;
      wa_q <= '0;
      ws_q <= '0;
    end else begin
      regs_q <= regs_d;
      stb_q <= stb_d;
      {ack_q, err_q, wip_q, rip_q} <= {ack_d, err_d, wip_d, rip_d};
      {wv_q, rv_q, rm_q} <= {acc_w, acc_r, rmap};
      {dat_q, rd_q, wd_q} <= {dat_d, rmux, wb.dat_i};
      wa_q <= wb.adr_i;
      ws_q <= wb.sel_i;
    end
  end
  assign wb.ack_o = ack_q;
  assign wb.err_o = err_q;
  assign wb.rty_o = 1'b0;
  assign wb.stall_o = en & ~(ack_q | err_q);
  assign wb.dat_o = dat_q;
  assign regs_o = regs_q;
  assign wr_stb_o = stb_q;
endmodule

// File: tb/tb_wb_regbank.sv
// tb_wb_regbank: self-checking bench for wb_regbank over several parameter sets
module tb_wb_regbank;
  localparam int ND = 6;
  localparam int NR [ND] = '{4, 3, 3, 4, 4, 3};
  localparam bit PW [ND] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam bit PR [ND] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  localparam bit EU [ND] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic [31:0] RV [ND] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hCAFE0000, 32'h00001234};
  typedef struct {
    int d;
    bit we;
    logic [1:0] a;
    logic [31:0] dt;
    logic [3:0] sl;
    logic [31:0] rd;
    bit er;
    logic [3:0] st;
  } vec_t;
  logic clk = 1'b0;
  logic rst, cyc, stb, we;
  logic [1:0] adr;
  logic [3:0] sel;
  logic [31:0] dat;
  int cur;
  logic [ND-1:0] ack_v, err_v, stall_v, rty_v;
  logic [31:0] dat_v [ND];
  logic [127:0] regs_v [ND];
  logic [3:0] stb_v [ND];
  logic ack_s, err_s, stall_s;
  logic [31:0] dat_s;
  logic [3:0] stb_s;
  logic [31:0] mem [ND][4];
  int nt = 0, nf = 0, nx = 0, nresp = 0;
  vec_t tv [27];
  always #5 clk = ~clk;
  for (genvar g = 0; g < ND; g++) begin : g_dut
    logic [32*NR[g]-1:0] r;
    logic [NR[g]-1:0] s;
    wb_regbank_if #(.AW(2)) bus ();
    assign bus.cyc_i = cyc & (cur == g);
    assign bus.stb_i = stb;
    assign bus.adr_i = adr;
    assign bus.sel_i = sel;
    assign bus.we_i = we;
    assign bus.dat_i = dat;
    assign ack_v[g] = bus.ack_o;
    assign err_v[g] = bus.err_o;
    assign stall_v[g] = bus.stall_o;
    assign rty_v[g] = bus.rty_o;
    assign dat_v[g] = bus.dat_o;
    assign regs_v[g] = 128'(r);
    assign stb_v[g] = 4'(s);
    wb_regbank #(.NREGS(NR[g]), .PIPE_WR(PW[g]), .PIPE_RD(PR[g]), .ERR_UNMAPPED(EU[g]), .RST_VAL(RV[g])) u_dut (
      .clk_i(clk), .rst_i(rst), .wb(bus), .regs_o(r), .wr_stb_o(s));
  end
  assign ack_s = ack_v[cur];
  assign err_s = err_v[cur];
  assign stall_s = stall_v[cur];
  assign dat_s = dat_v[cur];
  assign stb_s = stb_v[cur];
  always @(negedge clk) nresp <= nresp + $countones({ack_v, err_v});
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    nt++;
    if (a !== e) begin
      nf++;
      $display("FAIL %s: got %0h expected %0h (dut %0d, t=%0t)", n, a, e, cur, $time);
    end
  endtask
  task automatic mreset();
    for (int i = 0; i < ND; i++) for (int j = 0; j < 4; j++) mem[i][j] = RV[i];
  endtask
  function automatic logic [127:0] mregs(input int d);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < NR[d]; i++) r[32*i +: 32] = mem[d][i];
    return r;
  endfunction
  task automatic xfer(input int d, input bit w, input logic [1:0] a, input logic [31:0] dt, input logic [3:0] sl,
                      input logic [31:0] erd, input bit eer, input logic [3:0] est, input bit ab);
    int lat;
    bit got;
    logic [127:0] ereg;
    lat = 1 + int'(w ? PW[d] : PR[d]);
    if (w && a < NR[d]) for (int b = 0; b < 4; b++) if (sl[b]) mem[d][a][8*b +: 8] = dt[8*b +: 8];
    ereg = mregs(d);
    nx++;
    cur = d; cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = dt; sel = sl;
    #1 chk("stall_req", stall_s, 1);
    got = 1'b0;
    for (int k = 1; k <= 8 && !got; k++) begin
      @(negedge clk);
      if (ack_s | err_s) begin
        got = 1'b1;
        chk("latency", k, lat);
        chk("ack", ack_s, !eer);
        chk("err", err_s, eer);
        chk("stall_resp", stall_s, 0);
        if (!w) chk("rdata", dat_s, erd);
        chk("wr_stb", stb_s, est);
        chk("regs", regs_v[d], ereg);
      end else begin
        chk("stall_wait", stall_s, cyc);
        chk("wr_stb_wait", stb_s, 0);
      end
      if (ab || got) begin cyc = 1'b0; stb = 1'b0; end
    end
    if (!got) chk("timeout", 0, 1);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    chk("single_resp", ack_s | err_s, 0);
    chk("wr_stb_pulse", stb_s, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tv = '{
      '{0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h00000000, 1'b0, 4'b0000},
      '{0, 1'b0, 2'd1, 32'h0, 4'h0, 32'h00000000, 1'b0, 4'b0000},
      '{0, 1'b0, 2'd2, 32'h0, 4'h0, 32'h00000000, 1'b0, 4'b0000},
      '{0, 1'b0, 2'd3, 32'h0, 4'h0, 32'h00000000, 1'b0, 4'b0000},
      '{0, 1'b1, 2'd2, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 4'b0100},
      '{0, 1'b0, 2'd2, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 4'b0000},
      '{0, 1'b1, 2'd1, 32'h11223344, 4'hF, 32'h0, 1'b0, 4'b0010},
      '{0, 1'b1, 2'd1, 32'hAABBCCDD, 4'h5, 32'h0, 1'b0, 4'b0010},
      '{0, 1'b0, 2'd1, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 4'b0000},
      '{0, 1'b1, 2'd1, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0, 4'b0010},
      '{0, 1'b0, 2'd1, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 4'b0000},
      '{1, 1'b1, 2'd3, 32'h12345678, 4'hF, 32'h0, 1'b1, 4'b0000},
      '{1, 1'b0, 2'd3, 32'h0, 4'h0, 32'h00000000, 1'b1, 4'b0000},
      '{1, 1'b1, 2'd2, 32'h0BADCAFE, 4'hF, 32'h0, 1'b0, 4'b0100},
      '{1, 1'b0, 2'd2, 32'h0, 4'h0, 32'h0BADCAFE, 1'b0, 4'b0000},
      '{2, 1'b1, 2'd3, 32'h12345678, 4'hF, 32'h0, 1'b0, 4'b0000},
      '{2, 1'b0, 2'd3, 32'h0, 4'h0, 32'h00000000, 1'b0, 4'b0000},
      '{3, 1'b1, 2'd0, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0, 4'b0001},
      '{3, 1'b0, 2'd0, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0, 4'b0000},
      '{3, 1'b1, 2'd0, 32'h0000FFFF, 4'h3, 32'h0, 1'b0, 4'b0001},
      '{3, 1'b0, 2'd0, 32'h0, 4'h0, 32'hA5A5FFFF, 1'b0, 4'b0000},
      '{4, 1'b1, 2'd0, 32'h0BADF00D, 4'hF, 32'h0, 1'b0, 4'b0001},
      '{4, 1'b1, 2'd1, 32'h00C0FFEE, 4'hF, 32'h0, 1'b0, 4'b0010},
      '{5, 1'b0, 2'd3, 32'h0, 4'h0, 32'h00000000, 1'b1, 4'b0000},
      '{5, 1'b0, 2'd0, 32'h0, 4'h0, 32'h00001234, 1'b0, 4'b0000},
      '{5, 1'b1, 2'd0, 32'hFFFFFFFF, 4'h8, 32'h0, 1'b0, 4'b0001},
      '{5, 1'b0, 2'd0, 32'h0, 4'h0, 32'hFF001234, 1'b0, 4'b0000}
    };
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; sel = '0; dat = '0; cur = 0;
    mreset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int g = 0; g < ND; g++) begin
      chk("rst_regs", regs_v[g], mregs(g));
      chk("rst_resp", {ack_v[g], err_v[g], rty_v[g]}, 0);
      chk("rst_stb", stb_v[g], 0);
      chk("rst_dat", dat_v[g], 0);
    end
    for (int i = 0; i < 27; i++)
      xfer(tv[i].d, tv[i].we, tv[i].a, tv[i].dt, tv[i].sl, tv[i].rd, tv[i].er, tv[i].st, 1'b0);
    cur = 4; cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 2'd1; dat = 32'h12345678; sel = 4'hF;
    @(negedge clk);
    chk("midrst_wait_ack", ack_s | err_s, 0);
    chk("midrst_wait_stall", stall_s, 1);
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mreset();
    repeat (4) begin
      chk("midrst_no_resp", ack_s | err_s, 0);
      chk("midrst_no_stb", stb_s, 0);
      chk("midrst_stall", stall_s, 0);
      @(negedge clk);
    end
    chk("midrst_reg1", regs_v[4][63:32], 32'hCAFE0000);
    for (int g = 0; g < ND; g++) chk("midrst_regs", regs_v[g], mregs(g));
    xfer(4, 1'b0, 2'd1, 32'h0, 4'h0, 32'hCAFE0000, 1'b0, 4'b0000, 1'b0);
    xfer(0, 1'b1, 2'd2, 32'h600DF00D, 4'hF, 32'h0, 1'b0, 4'b0100, 1'b0);
    xfer(0, 1'b0, 2'd2, 32'h0, 4'h0, 32'h600DF00D, 1'b0, 4'b0000, 1'b1);
    xfer(0, 1'b0, 2'd3, 32'h0, 4'h0, 32'h00000000, 1'b0, 4'b0000, 1'b0);
    for (int n = 0; n < 240; n++) begin
      int d;
      bit w, ab;
      logic [1:0] a;
      logic [31:0] dt, erd;
      logic [3:0] sl, est;
      d = (n < 100) ? 3 : int'($urandom_range(0, ND - 1));
      w = 1'($urandom_range(0, 1));
      a = 2'($urandom_range(0, 3));
      dt = $urandom;
      sl = 4'($urandom_range(0, 15));
      ab = $urandom_range(0, 7) == 0;
      erd = (a < NR[d]) ? mem[d][a] : 32'h0;
      est = (w && a < NR[d]) ? 4'(1 << a) : 4'h0;
      xfer(d, w, a, dt, sl, erd, (a >= NR[d]) && EU[d], est, ab);
    end
    @(negedge clk);
    #1 chk("resp_count", nresp, nx);
    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end
endmodule
